// File: rtl/const_div_mod_pkg.sv
// Shared constants, operating-mode encodings and FSM states for the modular constant divider.
// Build option: define CONST_DIV_RADIX4_EN to retire two quotient bits per DIV3 cycle (W must be even).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CHAR
`define CHAR 2147483647
`endif

package const_div_mod_pkg;

  localparam int unsigned W = `WORD_SIZE;
  localparam logic [W-1:0] P = W'(`CHAR);

  // 3^-1 mod P and 2*3^-1 mod P; both exact because P mod 3 == 1
  localparam logic [W+1:0] P_X  = {2'b00, P};
  localparam logic [W-1:0] K1   = W'(((P_X << 1) + (W+2)'(1)) / (W+2)'(3));
  localparam logic [W-1:0] K2   = W'((P_X + (W+2)'(2)) / (W+2)'(3));

  localparam int unsigned CNT_W = $clog2(W);
`ifdef CONST_DIV_RADIX4_EN
  localparam int unsigned DIV3_STEPS = W / 2;
`else
  localparam int unsigned DIV3_STEPS = W;
`endif
  localparam logic [CNT_W-1:0] DIV3_LAST = CNT_W'(DIV3_STEPS - 1);

  typedef enum logic [1:0] {
    MODE_DIV2 = 2'b00,
    MODE_DIV4 = 2'b01,
    MODE_DIV3 = 2'b10,
    MODE_DIV6 = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALVE = 3'd1,
    ST_DIV3  = 3'd2,
    ST_FIX   = 3'd3,
    ST_NEG   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/const_div_mod_core_div3_step.sv
// One restoring radix-2 step of exact division by 3: shifts a bit into the 2-bit remainder.
module div3_step (
  input  logic [1:0] r_i,
  input  logic       bit_i,
  output logic [1:0] r_o,
  output logic       q_o
);

  logic [2:0] t;

  assign t   = {r_i, bit_i};
  assign q_o = (t >= 3'd3);
  assign r_o = q_o ? 2'(t - 3'd3) : t[1:0];

endmodule

// File: rtl/const_div_mod_core.sv
// Iterative modular constant divider: c = (+/-) a * k^-1 mod P for k in {2,4,3,6}.
// Build option: CONST_DIV_RADIX4_EN doubles the DIV3 throughput with two chained steps.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// HALVE | x = x/2 mod P, one cycle per factor of two
// DIV3  | bit-serial floor division of x by 3, quotient in q, remainder in r
// FIX   | x = q + r * 3^-1 mod P
// NEG   | optional negation, result written to c
// DONE  | out_valid high until the consumer accepts
module const_div_mod_core
  import const_div_mod_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [1:0]   mode_i,
  input  logic         invert_i,
  input  logic [W-1:0] a_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] c_o
);

  state_e           state_q, state_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     c_q, c_d;
  logic [1:0]       r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic             inv_q, inv_d;

  logic [W:0]       halve_sum;
  logic [W-1:0]     halved;
  logic [W-1:0]     div_x, div_q;
  logic [1:0]       div_r;
  logic [W-1:0]     fix_k, fix_sum;
  logic [W-1:0]     neg_val;
  logic [1:0]       r_s0;
  logic             q_s0;

  // odd x: x+P is even and fits in W+1 bits since x < P
  assign halve_sum = x_q[0] ? ({1'b0, x_q} + {1'b0, P}) : {1'b0, x_q};
  assign halved    = W'(halve_sum >> 1);

  div3_step u_step0 (.r_i(r_q), .bit_i(x_q[W-1]), .r_o(r_s0), .q_o(q_s0));

`ifdef CONST_DIV_RADIX4_EN
  logic [1:0] r_s1;
  logic       q_s1;

  div3_step u_step1 (.r_i(r_s0), .bit_i(x_q[W-2]), .r_o(r_s1), .q_o(q_s1));

  assign div_x = {x_q[W-3:0], 2'b00};
  assign div_q = {q_q[W-3:0], q_s0, q_s1};
  assign div_r = r_s1;
`else
  assign div_x = {x_q[W-2:0], 1'b0};
  assign div_q = {q_q[W-2:0], q_s0};
  assign div_r = r_s0;
`endif

  always_comb begin
    case (r_q)
      2'd1:    fix_k = K1;
      2'd2:    fix_k = K2;
      default: fix_k = '0;
    endcase
  end

  assign fix_sum = q_q + fix_k;
  assign neg_val = (inv_q && (x_q != '0)) ? (P - x_q) : x_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    q_d     = q_q;
    c_d     = c_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    inv_d   = inv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          x_d    = a_i;
          q_d    = '0;
          r_d    = '0;
          mode_d = mode_e'(mode_i);
          inv_d  = invert_i;
          if (mode_i == MODE_DIV3) begin
            state_d = ST_DIV3;
            cnt_d   = DIV3_LAST;
          end else begin
            state_d = ST_HALVE;
            cnt_d   = (mode_i == MODE_DIV4) ? CNT_W'(1) : '0;
          end
        end
      end
      ST_HALVE: begin
        x_d = halved;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (mode_q == MODE_DIV6) begin
          state_d = ST_DIV3;
          cnt_d   = DIV3_LAST;
        end else begin
          state_d = ST_NEG;
        end
      end
      ST_DIV3: begin
        x_d = div_x;
        q_d = div_q;
        r_d = div_r;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        x_d     = fix_sum;
        state_d = ST_NEG;
      end
      ST_NEG: begin
        c_d     = neg_val;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      q_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_DIV2;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      q_q     <= q_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign c_o         = c_q;

endmodule

// File: tb/tb_const_div_mod_core.sv
// Self-checking bench for const_div_mod_core: directed corner cases plus random operands
// against a modular-arithmetic reference model.
module tb_const_div_mod_core;
  import const_div_mod_pkg::W;
  import const_div_mod_pkg::P;

`ifdef CONST_DIV_RADIX4_EN
  localparam int STEPS = W / 2;
`else
  localparam int STEPS = W;
`endif
  localparam int N_RAND = 2000;
  localparam int LAT_MAX = 300;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   mode = 2'b00;
  logic         invert = 1'b0;
  logic [W-1:0] a = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] c;

  int checks = 0;
  int errors = 0;

  const_div_mod_core dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .mode_i     (mode),
    .invert_i   (invert),
    .a_i        (a),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .c_o        (c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W+3:0] obs, input logic [W+3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int k_of(input logic [1:0] m);
    case (m)
      2'b00:   return 2;
      2'b01:   return 4;
      2'b10:   return 3;
      default: return 6;
    endcase
  endfunction

  // c is the unique value in [0,P) with c*k == a (mod P): pick the j making a + j*P divisible by k
  function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [1:0] m, input logic inv);
    logic [W+3:0] t, res, k;
    k   = (W+4)'(k_of(m));
    res = '0;
    for (int j = 0; j < 6; j++) begin
      t = {4'b0, av} + (W+4)'(j) * {4'b0, P};
      if ((W+4)'(j) < k && (t % k) == '0) begin
        res = t / k;
        break;
      end
    end
    if (inv && res != '0) res = {4'b0, P} - res;
    return res[W-1:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] m);
    case (m)
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return STEPS + 2;
      default: return STEPS + 3;
    endcase
  endfunction

  task automatic start_op(input logic [W-1:0] av, input logic [1:0] m, input logic inv);
    @(negedge clk);
    a = av; mode = m; invert = inv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] cv, output int lat);
    lat = 0;
    while (!out_valid && lat < LAT_MAX) begin
      @(posedge clk);
      #1;
      lat++;
    end
    cv = c;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [1:0] m,
                        input logic inv, output logic [W-1:0] cv);
    int lat;
    start_op(av, m, inv);
    wait_result(cv, lat);
    chk({tag, "_lat"}, (W+4)'(lat), (W+4)'(exp_lat(m)));
    chk({tag, "_c"}, {4'b0, cv}, {4'b0, model(av, m, inv)});
    finish_op();
  endtask

  initial begin
    logic [W-1:0] cv, hold;
    logic [W+3:0] prod;
    int lat;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {{(W+3){1'b0}}, in_ready}, 1);
    chk("rst_out_valid", {{(W+3){1'b0}}, out_valid}, 0);
    chk("rst_c", {4'b0, c}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("a6_div2", W'(6), 2'b00, 1'b0, cv);
    chk("a6_div2_val", {4'b0, cv}, 3);
    run_op("a1_div2", W'(1), 2'b00, 1'b0, cv);
    chk("a1_div2_val", {4'b0, cv}, ({4'b0, P} + 1) / 2);
    run_op("a1_div3", W'(1), 2'b10, 1'b0, cv);
    chk("a1_div3_val", {4'b0, cv}, (2 * {4'b0, P} + 1) / 3);
    run_op("a2_div3", W'(2), 2'b10, 1'b0, cv);
    chk("a2_div3_val", {4'b0, cv}, ({4'b0, P} + 2) / 3);
    run_op("a9_div6", W'(9), 2'b11, 1'b0, cv);
    prod = ({4'b0, cv} * 6) % {4'b0, P};
    chk("a9_div6_times6", prod, 9);
    run_op("a2_div2_inv", W'(2), 2'b00, 1'b1, cv);
    chk("a2_div2_inv_val", {4'b0, cv}, {4'b0, P} - 1);
    for (int m = 0; m < 4; m++) begin
      run_op("zero_inv", '0, 2'(m), 1'b1, cv);
      chk("zero_inv_val", {4'b0, cv}, 0);
    end
    run_op("pm1_div4", P - W'(1), 2'b01, 1'b0, cv);
    run_op("pm1_div6_inv", P - W'(1), 2'b11, 1'b1, cv);

    // consumer stall: result must hold and new operands must be ignored
    start_op(W'(10), 2'b11, 1'b0);
    wait_result(hold, lat);
    chk("stall_lat", (W+4)'(lat), (W+4)'(exp_lat(2'b11)));
    chk("stall_c", {4'b0, hold}, {4'b0, model(W'(10), 2'b11, 1'b0)});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = W'(77 + i);
      mode = 2'b00;
      @(posedge clk);
      #1;
      chk("stall_out_valid", {{(W+3){1'b0}}, out_valid}, 1);
      chk("stall_c_hold", {4'b0, c}, {4'b0, hold});
      chk("stall_in_ready", {{(W+3){1'b0}}, in_ready}, 0);
    end
    in_valid = 1'b0;
    finish_op();
    chk("post_hs_in_ready", {{(W+3){1'b0}}, in_ready}, 1);
    chk("post_hs_out_valid", {{(W+3){1'b0}}, out_valid}, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("no_spurious_op", {{(W+3){1'b0}}, out_valid}, 0);
    chk("c_holds_after_hs", {4'b0, c}, {4'b0, hold});

    // asynchronous reset part-way through DIV3
    start_op(W'(12345), 2'b10, 1'b0);
    repeat (STEPS / 2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {{(W+3){1'b0}}, out_valid}, 0);
    chk("midrst_in_ready", {{(W+3){1'b0}}, in_ready}, 1);
    chk("midrst_c", {4'b0, c}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("a12_div4", W'(12), 2'b01, 1'b0, cv);
    chk("a12_div4_val", {4'b0, cv}, 3);

    for (int n = 0; n < N_RAND; n++) begin
      logic [W-1:0] av;
      logic [1:0]   m;
      logic         inv;
      case ($urandom_range(0, 9))
        0:       av = '0;
        1:       av = P - W'(1);
        default: av = W'($urandom) % P;
      endcase
      m   = 2'($urandom_range(0, 3));
      inv = 1'($urandom_range(0, 1));
      run_op("rand", av, m, inv, cv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
